// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO: shift-register storage with registered occupancy and flags.
// Show-ahead read: the oldest token sits on if_dout whenever if_empty_n is high.
module pe_start_token_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_n_q, full_n_q;
    logic                  push, pop;

    assign push = if_write_ce & if_write & full_n_q;
    assign pop  = if_read_ce  & if_read  & empty_n_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
    end

    // Flags derive from next-count so they are plain flops on the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            empty_n_q <= (count_d != '0);
            full_n_q  <= (count_d != CNT_FULL);
        end
    end

    // Storage has no reset so it maps onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[0] <= if_din;
            for (int i = 1; i < DEPTH; i++)
                mem_q[i] <= mem_q[i-1];
        end
    end

    // Read tap at slot count-1; count==0 selects nothing and yields zero.
    always_comb begin
        if_dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (count_q == (ADDR_WIDTH+1)'(i+1))
                if_dout = mem_q[i];
    end

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = count_q;
endmodule

// File: tb/tb_pe_start_token_fifo.sv
// Bench: directed vector table on a DEPTH=4 x 8-bit instance, then random
// push/pop/reset on the default DEPTH=2 x 1-bit instance against a queue model.
module tb_pe_start_token_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=4, 8-bit instance
    logic       r4_n = 1'b0, wce4 = 1'b0, wr4 = 1'b0, rce4 = 1'b0, rd4 = 1'b0;
    logic [7:0] din4 = '0, dout4;
    logic       full4, empty4;
    logic [2:0] cnt4;

    pe_start_token_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut4 (
        .clk(clk), .reset_n(r4_n),
        .if_write_ce(wce4), .if_write(wr4), .if_din(din4), .if_full_n(full4),
        .if_read_ce(rce4), .if_read(rd4), .if_dout(dout4), .if_empty_n(empty4),
        .if_num_data_valid(cnt4)
    );

    // Default-parameter instance
    logic       r2_n = 1'b0, wce2 = 1'b0, wr2 = 1'b0, rce2 = 1'b0, rd2 = 1'b0;
    logic [0:0] din2 = '0, dout2;
    logic       full2, empty2;
    logic [1:0] cnt2;

    pe_start_token_fifo dut2 (
        .clk(clk), .reset_n(r2_n),
        .if_write_ce(wce2), .if_write(wr2), .if_din(din2), .if_full_n(full2),
        .if_read_ce(rce2), .if_read(rd2), .if_dout(dout2), .if_empty_n(empty2),
        .if_num_data_valid(cnt2)
    );

    typedef struct {
        logic       rst_n, wce, wr, rce, rd;
        logic [7:0] din;
        logic       full_n, empty_n;
        logic [2:0] cnt;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rn, input logic wce, input logic wr, input logic rce,
                       input logic rd, input logic [7:0] din, input logic fn, input logic en,
                       input logic [2:0] cnt, input logic [7:0] dout);
        vec_t v;
        v.rst_n = rn; v.wce = wce; v.wr = wr; v.rce = rce; v.rd = rd; v.din = din;
        v.full_n = fn; v.empty_n = en; v.cnt = cnt; v.dout = dout;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    logic q[$];
    logic rn, wce, wr, rce, rd, d, p_push, p_pop;

    initial begin
        // rst wce wr rce rd din | full_n empty_n cnt dout   (values after the edge)
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1, 8'hEE, 1, 0, 0, 8'h00);
        add(1, 0, 0, 1, 1, 8'h00, 1, 0, 0, 8'h00);  // pop on empty ignored
        add(1, 0, 0, 1, 1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 1, 1, 0, 0, 8'hA1, 1, 1, 1, 8'hA1);
        add(1, 1, 1, 0, 0, 8'hA2, 1, 1, 2, 8'hA1);
        add(1, 1, 1, 0, 0, 8'hA3, 1, 1, 3, 8'hA1);
        add(1, 1, 1, 0, 0, 8'hA4, 0, 1, 4, 8'hA1);
        add(1, 1, 1, 0, 0, 8'hFF, 0, 1, 4, 8'hA1);  // dropped while full
        add(1, 0, 0, 1, 1, 8'h00, 1, 1, 3, 8'hA2);
        add(1, 0, 0, 1, 1, 8'h00, 1, 1, 2, 8'hA3);
        add(1, 0, 0, 1, 1, 8'h00, 1, 1, 1, 8'hA4);
        add(1, 0, 0, 1, 1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 1, 1, 0, 0, 8'h11, 1, 1, 1, 8'h11);
        add(1, 1, 1, 0, 0, 8'h22, 1, 1, 2, 8'h11);
        add(1, 1, 1, 1, 1, 8'h33, 1, 1, 2, 8'h22);  // push+pop at count 2
        add(1, 1, 1, 0, 0, 8'h44, 1, 1, 3, 8'h22);
        add(1, 1, 1, 0, 0, 8'h55, 0, 1, 4, 8'h22);
        add(1, 1, 1, 1, 1, 8'h66, 1, 1, 3, 8'h33);  // both at full: pop only
        add(1, 0, 0, 1, 1, 8'h00, 1, 1, 2, 8'h44);
        add(1, 0, 0, 1, 1, 8'h00, 1, 1, 1, 8'h55);
        add(1, 0, 0, 1, 1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 1, 1, 1, 1, 8'h77, 1, 1, 1, 8'h77);  // both at empty: push only
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 0, 8'h99, 1, 1, 1, 8'h77);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 8'h00, 1, 1, 1, 8'h77);
        add(1, 1, 1, 0, 0, 8'h88, 1, 1, 2, 8'h77);
        add(1, 1, 1, 0, 0, 8'h89, 1, 1, 3, 8'h77);
        add(0, 1, 1, 0, 0, 8'hAA, 1, 0, 0, 8'h00);  // reset beats push
        add(1, 1, 1, 0, 0, 8'h5C, 1, 1, 1, 8'h5C);
        add(1, 1, 1, 1, 1, 8'h5D, 1, 1, 1, 8'h5D);  // streaming push+pop
        add(1, 1, 1, 1, 1, 8'h5E, 1, 1, 1, 8'h5E);

        foreach (tbl[i]) begin
            @(negedge clk);
            r4_n = tbl[i].rst_n; wce4 = tbl[i].wce; wr4 = tbl[i].wr;
            rce4 = tbl[i].rce;   rd4  = tbl[i].rd;  din4 = tbl[i].din;
            @(posedge clk); #1;
            chk($sformatf("v%0d_full_n", i),  full4,  tbl[i].full_n);
            chk($sformatf("v%0d_empty_n", i), empty4, tbl[i].empty_n);
            chk($sformatf("v%0d_count", i),   cnt4,   tbl[i].cnt);
            chk($sformatf("v%0d_dout", i),    dout4,  tbl[i].dout);
        end

        // Hand sequence: 3-cycle reset of the small instance, then idle read pulse.
        @(negedge clk); r2_n = 1'b0; wce2 = 1'b1; wr2 = 1'b1; din2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("r2_count", cnt2, 0);
        chk("r2_empty_n", empty2, 0);
        chk("r2_full_n", full2, 1);
        @(negedge clk); r2_n = 1'b1; wce2 = 1'b0; wr2 = 1'b0; rce2 = 1'b1; rd2 = 1'b1;
        @(posedge clk); #1;
        chk("r2_idle_read", {cnt2, empty2, full2, dout2}, {2'd0, 1'b0, 1'b1, 1'b0});

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rn  = ($urandom_range(0, 199) != 0);
            wce = ($urandom_range(0, 7) != 0);
            wr  = ($urandom_range(0, 1) != 0);
            rce = ($urandom_range(0, 7) != 0);
            rd  = ($urandom_range(0, 1) != 0);
            d   = 1'($urandom);
            r2_n = rn; wce2 = wce; wr2 = wr; rce2 = rce; rd2 = rd; din2 = d;
            p_push = wce & wr & (q.size() < 2);
            p_pop  = rce & rd & (q.size() > 0);
            @(posedge clk); #1;
            if (!rn) q.delete();
            else begin
                if (p_pop)  void'(q.pop_front());
                if (p_push) q.push_back(d);
            end
            chk($sformatf("rnd%0d_count", c),   cnt2,   q.size());
            chk($sformatf("rnd%0d_empty_n", c), empty2, q.size() != 0);
            chk($sformatf("rnd%0d_full_n", c),  full2,  q.size() != 2);
            chk($sformatf("rnd%0d_dout", c),    dout2,  (q.size() != 0) ? q[0] : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
